// File: rtl/systolic_2x2_sequencer_if.sv
// Stream and array-side bundle for the 2x2 systolic sequencer.
// The sequencer connects through slave; the host/array side connects through master.
interface systolic_2x2_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 32
);
    logic                         cfg_valid;
    logic                         cfg_ready;
    logic signed [DATA_WIDTH-1:0] cfg_weight;
    logic                         act_valid;
    logic                         act_ready;
    logic signed [DATA_WIDTH-1:0] act_data;
    logic                         act_last;
    logic                         load_en;
    logic signed [DATA_WIDTH-1:0] weight_out;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic signed [ACC_WIDTH-1:0]  row0_in;
    logic signed [ACC_WIDTH-1:0]  row1_in;
    logic                         res_valid;
    logic                         res_ready;
    logic signed [ACC_WIDTH-1:0]  res_row0;
    logic signed [ACC_WIDTH-1:0]  res_row1;
    logic                         busy;

    modport slave (
        input  cfg_valid, cfg_weight, act_valid, act_data, act_last,
        input  row0_in, row1_in, res_ready,
        output cfg_ready, act_ready, load_en, weight_out, data_out,
        output res_valid, res_row0, res_row1, busy
    );

    modport master (
        output cfg_valid, cfg_weight, act_valid, act_data, act_last,
        output row0_in, row1_in, res_ready,
        input  cfg_ready, act_ready, load_en, weight_out, data_out,
        input  res_valid, res_row0, res_row1, busy
    );
endinterface

// File: rtl/systolic_2x2_sequencer.sv
// Weight loader, activation issuer and credit-controlled result FIFO
// placed in front of a 2x2 weight-stationary systolic array.
module systolic_2x2_sequencer #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ACC_WIDTH      = 32,
    parameter int unsigned RESULT_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input logic                    clk,
    input logic                    rst,
    systolic_2x2_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IW = $clog2(RESULT_LATENCY + 1);

    typedef struct packed {
        logic signed [ACC_WIDTH-1:0] row0;
        logic signed [ACC_WIDTH-1:0] row1;
    } result_t;

    logic [1:0]                state, state_n;
    logic [1:0]                wcnt, wcnt_n;
    logic [RESULT_LATENCY-1:0] tok, tok_n;
    logic [IW-1:0]             inflight, inflight_n;
    logic [CW-1:0]             count, count_n;
    logic [PW-1:0]             wr_ptr, rd_ptr;
    result_t                   mem [FIFO_DEPTH];
    logic                      cfg_ready_n, act_ready_n, busy_n;
    logic                      cfg_acc, act_acc, push, pop;

    assign cfg_acc = bus.cfg_valid && bus.cfg_ready;
    assign act_acc = bus.act_valid && bus.act_ready;
    assign push    = tok[RESULT_LATENCY-1];
    assign pop     = bus.res_valid && bus.res_ready;

    assign bus.res_row0 = mem[rd_ptr].row0;
    assign bus.res_row1 = mem[rd_ptr].row1;

    // Next-state, token pipeline and credit accounting; ready flags are precomputed for registering.
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        case (state)
            S_IDLE: begin
                if (cfg_acc) begin
                    state_n = S_LOAD;
                    wcnt_n  = 2'd1;
                end
            end
            S_LOAD: begin
                if (cfg_acc) begin
                    if (wcnt == 2'd3) begin
                        state_n = S_STREAM;
                        wcnt_n  = 2'd0;
                    end else begin
                        wcnt_n = wcnt + 2'd1;
                    end
                end
            end
            S_STREAM: begin
                if (act_acc && bus.act_last) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if ((inflight == '0) && (count == '0)) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        tok_n       = RESULT_LATENCY'({tok, act_acc});
        inflight_n  = inflight + IW'(act_acc) - IW'(push);
        count_n     = count + CW'(push) - CW'(pop);
        cfg_ready_n = (state_n == S_IDLE) || (state_n == S_LOAD);
        act_ready_n = (state_n == S_STREAM) &&
                      ((32'(inflight_n) + 32'(count_n)) < FIFO_DEPTH);
        busy_n      = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            wcnt           <= '0;
            tok            <= '0;
            inflight       <= '0;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            bus.cfg_ready  <= 1'b1;
            bus.act_ready  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.load_en    <= 1'b0;
            bus.weight_out <= '0;
            bus.data_out   <= '0;
            bus.res_valid  <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
        end else begin
            state          <= state_n;
            wcnt           <= wcnt_n;
            tok            <= tok_n;
            inflight       <= inflight_n;
            count          <= count_n;
            bus.cfg_ready  <= cfg_ready_n;
            bus.act_ready  <= act_ready_n;
            bus.busy       <= busy_n;
            bus.res_valid  <= (count_n != '0);
            bus.load_en    <= cfg_acc;
            if (cfg_acc) bus.weight_out <= bus.cfg_weight;
            // Idle cycles present zero so the array sees no stale activation.
            bus.data_out   <= act_acc ? bus.act_data : '0;
            if (push) begin
                mem[wr_ptr] <= '{row0: bus.row0_in, row1: bus.row1_in};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end
endmodule

// File: tb/tb_systolic_2x2_sequencer.sv
// Directed bench for systolic_2x2_sequencer with a one-register array model
// returning row0 = 3*x and row1 = 7*x.
module tb_systolic_2x2_sequencer;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 32;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_2x2_sequencer_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

    systolic_2x2_sequencer #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .RESULT_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Array stand-in: result of data_out is present LAT edges after the accept edge.
    always @(posedge clk) begin
        bus.row0_in <= AW'(bus.data_out) * 3;
        bus.row1_in <= AW'(bus.data_out) * 7;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dcnt  = 0;
    int sent  = 0;
    int stall = 0;
    int s     = 0;
    int n     = 0;
    logic acc;
    logic signed [AW-1:0] rq0[$];
    logic signed [AW-1:0] rq1[$];
    int                   pcyc[$];
    logic signed [DW-1:0] wq[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus.load_en) wq.push_back(bus.weight_out);
            if (bus.data_out != 0) dcnt <= dcnt + 1;
            if (bus.res_valid && bus.res_ready) begin
                rq0.push_back(bus.res_row0);
                rq1.push_back(bus.res_row1);
                pcyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cfg_ready"}, bus.cfg_ready, 1);
        chk({tag, "_act_ready"}, bus.act_ready, 0);
        chk({tag, "_load_en"}, bus.load_en, 0);
        chk({tag, "_weight_out"}, bus.weight_out, 0);
        chk({tag, "_data_out"}, bus.data_out, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_row0"}, bus.res_row0, 0);
        chk({tag, "_res_row1"}, bus.res_row1, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic clear_mon();
        rq0.delete(); rq1.delete(); pcyc.delete(); wq.delete();
        dcnt = 0;
    endtask

    task automatic load_w(input int a, input int b, input int c, input int d);
        int w[4];
        w = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            bus.cfg_valid  = 1'b1;
            bus.cfg_weight = DW'(w[i]);
            @(negedge clk);
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic send_act(input int d, input logic l, output int stalls);
        stalls        = 0;
        bus.act_valid = 1'b1;
        bus.act_data  = DW'(d);
        bus.act_last  = l;
        while (!bus.act_ready && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        @(negedge clk);
        bus.act_valid = 1'b0;
        bus.act_last  = 1'b0;
    endtask

    task automatic stream_step();
        bus.act_valid = (sent < 10);
        bus.act_data  = DW'(sent + 1);
        bus.act_last  = (sent == 9);
        acc = bus.act_valid && bus.act_ready;
        @(negedge clk);
        if (acc) sent++;
    endtask

    task automatic wait_idle(input string tag);
        n = 0;
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_valid = 0; bus.cfg_weight = 0;
        bus.act_valid = 0; bus.act_data = 0; bus.act_last = 0;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        @(negedge clk);

        // Weight load 4,3,2,1 with act_valid held high (must be ignored)
        clear_mon();
        bus.act_valid = 1'b1; bus.act_data = 16'sd99;
        for (int i = 0; i < 4; i++) begin
            bus.cfg_valid  = 1'b1;
            bus.cfg_weight = DW'(4 - i);
            @(negedge clk);
            chk("ld_load_en", bus.load_en, 1);
            chk("ld_weight_out", bus.weight_out, 4 - i);
            chk("ld_no_data", bus.data_out, 0);
        end
        bus.act_valid = 1'b0;
        chk("ld_cfg_ready", bus.cfg_ready, 0);
        chk("ld_busy", bus.busy, 1);
        chk("ld_act_ready", bus.act_ready, 1);

        // Single activation, cfg_valid still high in STREAM (must be ignored)
        bus.cfg_weight = 16'sd77;
        bus.act_valid = 1'b1; bus.act_data = 16'sd5; bus.act_last = 1'b1;
        @(negedge clk);
        bus.act_valid = 1'b0; bus.act_last = 1'b0;
        chk("one_data_out", bus.data_out, 5);
        chk("one_no_load", bus.load_en, 0);
        chk("one_act_ready", bus.act_ready, 0);
        chk("one_valid_t1", bus.res_valid, 0);
        @(negedge clk);
        chk("one_valid_t2", bus.res_valid, 0);
        @(negedge clk);
        chk("one_valid_t3", bus.res_valid, 1);
        chk("one_row0", bus.res_row0, 15);
        chk("one_row1", bus.res_row1, 35);
        bus.cfg_valid = 1'b0;
        wait_idle("one");
        chk("one_cfg_ready", bus.cfg_ready, 1);
        chk("one_wq_n", wq.size(), 4);
        if (wq.size() == 4) for (int i = 0; i < 4; i++) chk("one_wq", wq[i], 4 - i);
        chk("one_dcnt", dcnt, 1);
        chk("one_nres", rq0.size(), 1);
        if (rq0.size() == 1) begin
            chk("one_q0", rq0[0], 15);
            chk("one_q1", rq1[0], 35);
        end

        // Streaming 8 back-to-back
        clear_mon();
        load_w(4, 3, 2, 1);
        stall = 0;
        for (int i = 1; i <= 8; i++) begin
            send_act(i, (i == 8), s);
            stall += s;
        end
        wait_idle("str");
        chk("str_stalls", stall, 0);
        chk("str_nres", rq0.size(), 8);
        if (rq0.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("str_row0", rq0[i], 3 * (i + 1));
                chk("str_row1", rq1[i], 7 * (i + 1));
            end
            chk("str_gapless", pcyc[7] - pcyc[0], 7);
        end

        // Backpressure: 10 activations with res_ready low first
        clear_mon();
        load_w(4, 3, 2, 1);
        bus.res_ready = 1'b0;
        sent = 0;
        repeat (12) stream_step();
        chk("bp_sent", sent, 4);
        chk("bp_act_ready", bus.act_ready, 0);
        chk("bp_res_valid", bus.res_valid, 1);
        chk("bp_head0", bus.res_row0, 3);
        chk("bp_head1", bus.res_row1, 7);
        chk("bp_none_out", rq0.size(), 0);
        bus.res_ready = 1'b1;
        n = 0;
        while (sent < 10 && n < 100) begin
            stream_step();
            n++;
        end
        bus.act_valid = 1'b0; bus.act_last = 1'b0;
        chk("bp_sent_all", sent, 10);
        wait_idle("bp");
        chk("bp_nres", rq0.size(), 10);
        if (rq0.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                chk("bp_row0", rq0[i], 3 * (i + 1));
                chk("bp_row1", rq1[i], 7 * (i + 1));
            end
        end

        // Reset mid-stream with two results held in the FIFO
        load_w(4, 3, 2, 1);
        bus.res_ready = 1'b0;
        send_act(11, 1'b0, s);
        send_act(12, 1'b0, s);
        repeat (2) @(negedge clk);
        chk("mr_fifo_full2", bus.res_valid, 1);
        chk("mr_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mr");
        rst = 1'b0;
        bus.res_ready = 1'b1;
        clear_mon();
        @(negedge clk);
        load_w(1, 2, 3, 4);
        send_act(2, 1'b1, s);
        wait_idle("mr");
        @(negedge clk);
        chk("mr_nres", rq0.size(), 1);
        if (rq0.size() == 1) begin
            chk("mr_row0", rq0[0], 6);
            chk("mr_row1", rq1[0], 14);
        end
        chk("mr_wq_n", wq.size(), 4);
        if (wq.size() == 4) for (int i = 0; i < 4; i++) chk("mr_wq", wq[i], i + 1);
        chk("mr_dcnt", dcnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
